// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: owns the PC, runs a single-outstanding
// request/grant/response handshake to instruction memory, and drives the
// IF side of the IF/ID register (bubble = NOP whenever nothing is valid).
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTRUCTION = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid_out,
  output logic [31:0] if_pc_out,
  output logic [31:0] if_pc_plus_4_out,
  output logic [31:0] if_instruction_out
);

  // REQ: asking; WAIT: granted, awaiting data; HOLD: data buffered under
  // stall; DROP: granted request whose response must be thrown away.
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DROP} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] hold_q, hold_d;
  logic        req_c;
  logic        vld_c;
  logic [31:0] instr_c;
  logic [31:0] pc_inc;
  logic [31:0] redir_tgt;

  assign pc_inc    = pc_q + 32'd4;
  assign redir_tgt = {redirect_pc[31:2], 2'b00};

  // State, PC and hold buffer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      hold_q  <= hold_d;
    end
  end

  // Next state, PC update and handshake/presentation decode
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    hold_d    = hold_q;
    req_c     = 1'b0;
    imem_addr = pc_q;
    vld_c     = 1'b0;
    instr_c   = NOP_INSTRUCTION;
    case (state_q)
      S_REQ: begin
        // Request stays up at the current PC even in a redirect cycle; the
        // address only moves on the following cycle.
        req_c = 1'b1;
        if (redirect_valid) begin
          pc_d    = redir_tgt;
          state_d = imem_gnt ? S_DROP : S_REQ;
        end else if (imem_gnt) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          pc_d    = redir_tgt;
          state_d = imem_rvalid ? S_REQ : S_DROP;
        end else if (imem_rvalid) begin
          // Shown even under stall; IF/ID simply does not capture it.
          vld_c   = 1'b1;
          instr_c = imem_rdata;
          if (stall) begin
            hold_d  = imem_rdata;
            state_d = S_HOLD;
          end else begin
            // Consume and immediately fetch the next word.
            pc_d      = pc_inc;
            req_c     = 1'b1;
            imem_addr = pc_inc;
            state_d   = imem_gnt ? S_WAIT : S_REQ;
          end
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          pc_d    = redir_tgt;
          state_d = S_REQ;
        end else begin
          vld_c   = 1'b1;
          instr_c = hold_q;
          if (!stall) begin
            pc_d    = pc_inc;
            state_d = S_REQ;
          end
        end
      end
      S_DROP: begin
        if (redirect_valid) pc_d = redir_tgt;
        if (imem_rvalid) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase
  end

  // No request escapes while reset is held, whatever state it left behind.
  assign imem_req           = req_c & rst_n;
  assign if_valid_out       = vld_c;
  assign if_pc_out          = vld_c ? pc_q   : 32'd0;
  assign if_pc_plus_4_out   = vld_c ? pc_inc : 32'd0;
  assign if_instruction_out = vld_c ? instr_c : NOP_INSTRUCTION;

endmodule
